// File: rtl/wb_arbiter.sv
// Round-robin arbiter that lets N Wishbone B4 pipelined masters share a
// single slave port. Ownership is granted from IDLE only. It lasts for as
// long as the owner holds CYC. Between two owners the slave always sees at
// least one cycle with CYC low.
module wb_arbiter #(
    parameter int N = 2
) (
    input  logic            wb_clk_i,
    input  logic            wb_rst_i,
    // master side
    input  logic [N-1:0]    m_wb_cyc_i,
    input  logic [N-1:0]    m_wb_stb_i,
    input  logic [N-1:0]    m_wb_we_i,
    input  logic [4*N-1:0]  m_wb_sel_i,
    input  logic [16*N-1:0] m_wb_adr_i,
    input  logic [32*N-1:0] m_wb_dat_i,
    output logic [31:0]     m_wb_dat_o,
    output logic [N-1:0]    m_wb_stall_o,
    output logic [N-1:0]    m_wb_ack_o,
    // slave side
    output logic            s_wb_cyc_o,
    output logic            s_wb_stb_o,
    output logic            s_wb_we_o,
    output logic [3:0]      s_wb_sel_o,
    output logic [15:0]     s_wb_adr_o,
    output logic [31:0]     s_wb_dat_o,
    input  logic [31:0]     s_wb_dat_i,
    input  logic            s_wb_stall_i,
    input  logic            s_wb_ack_i,
    // current owner, one-hot, zero when idle
    output logic [N-1:0]    grant_o
);

    localparam int IW = $clog2(N);

    typedef enum logic {
        IDLE,
        BUSY
    } state_e;

    state_e         state_q, state_d;
    logic [N-1:0]   grant_q, grant_d;
    logic [IW-1:0]  last_q,  last_d;

    // State, grant and last-owner registers; reset gives master 0 first priority.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q <= IDLE;
            grant_q <= '0;
            last_q  <= IW'(N - 1);
        end else begin
            // NOTE: sequential state uses <= so every register samples pre-edge values.
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
        end
    end

    // Next-state: round-robin pick from IDLE, release when the owner drops CYC.
    always_comb begin
        logic          found;
        logic [IW-1:0] cand;
        // NOTE: defaults first so no path leaves a variable unassigned (no latches).
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        found   = 1'b0;
        cand    = '0;
        case (state_q)
            IDLE: begin
                grant_d = '0;
                if (|m_wb_cyc_i) begin
                    // Search starts just after the most recent owner.
                    for (int k = 1; k <= N; k++) begin
                        cand = IW'((int'(last_q) + k) % N);
                        if (!found && m_wb_cyc_i[cand]) begin
                            found         = 1'b1;
                            grant_d[cand] = 1'b1;
                            last_d        = cand;
                        end
                    end
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (!(|(m_wb_cyc_i & grant_q))) begin
                    state_d = IDLE;
                    grant_d = '0;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    // AND-OR mux of the granted master onto the slave port; all zero when idle.
    always_comb begin
        s_wb_cyc_o = 1'b0;
        s_wb_stb_o = 1'b0;
        s_wb_we_o  = 1'b0;
        s_wb_sel_o = '0;
        s_wb_adr_o = '0;
        s_wb_dat_o = '0;
        for (int i = 0; i < N; i++) begin
            s_wb_cyc_o = s_wb_cyc_o | (m_wb_cyc_i[i] & grant_q[i]);
            s_wb_stb_o = s_wb_stb_o | (m_wb_stb_i[i] & grant_q[i]);
            s_wb_we_o  = s_wb_we_o  | (m_wb_we_i[i]  & grant_q[i]);
            s_wb_sel_o = s_wb_sel_o | (m_wb_sel_i[4*i +: 4]   & {4{grant_q[i]}});
            s_wb_adr_o = s_wb_adr_o | (m_wb_adr_i[16*i +: 16] & {16{grant_q[i]}});
            s_wb_dat_o = s_wb_dat_o | (m_wb_dat_i[32*i +: 32] & {32{grant_q[i]}});
        end
    end

    // Non-owners are held off with STALL and never see ACK; read data is broadcast.
    always_comb begin
        m_wb_stall_o = ~grant_q | {N{s_wb_stall_i}};
        m_wb_ack_o   = grant_q & {N{s_wb_ack_i}};
        m_wb_dat_o   = s_wb_dat_i;
    end

    assign grant_o = grant_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter (N=2). It runs directed scenarios first and then
// randomized traffic. The random traffic is checked against an
// owner/last-owner reference model.
module tb_wb_arbiter;

    localparam int N = 2;

    logic            wb_clk_i = 1'b0;
    logic            wb_rst_i;
    logic [N-1:0]    m_wb_cyc_i, m_wb_stb_i, m_wb_we_i;
    logic [4*N-1:0]  m_wb_sel_i;
    logic [16*N-1:0] m_wb_adr_i;
    logic [32*N-1:0] m_wb_dat_i;
    logic [31:0]     m_wb_dat_o;
    logic [N-1:0]    m_wb_stall_o, m_wb_ack_o;
    logic            s_wb_cyc_o, s_wb_stb_o, s_wb_we_o;
    logic [3:0]      s_wb_sel_o;
    logic [15:0]     s_wb_adr_o;
    logic [31:0]     s_wb_dat_o;
    logic [31:0]     s_wb_dat_i;
    logic            s_wb_stall_i, s_wb_ack_i;
    logic [N-1:0]    grant_o;

    int tests_run    = 0;
    int tests_failed = 0;

    // reference model: current owner (-1 = idle) and most recent owner
    int m_owner;
    int m_last;

    wb_arbiter #(.N(N)) dut (
        .wb_clk_i     (wb_clk_i),
        .wb_rst_i     (wb_rst_i),
        .m_wb_cyc_i   (m_wb_cyc_i),
        .m_wb_stb_i   (m_wb_stb_i),
        .m_wb_we_i    (m_wb_we_i),
        .m_wb_sel_i   (m_wb_sel_i),
        .m_wb_adr_i   (m_wb_adr_i),
        .m_wb_dat_i   (m_wb_dat_i),
        .m_wb_dat_o   (m_wb_dat_o),
        .m_wb_stall_o (m_wb_stall_o),
        .m_wb_ack_o   (m_wb_ack_o),
        .s_wb_cyc_o   (s_wb_cyc_o),
        .s_wb_stb_o   (s_wb_stb_o),
        .s_wb_we_o    (s_wb_we_o),
        .s_wb_sel_o   (s_wb_sel_o),
        .s_wb_adr_o   (s_wb_adr_o),
        .s_wb_dat_o   (s_wb_dat_o),
        .s_wb_dat_i   (s_wb_dat_i),
        .s_wb_stall_i (s_wb_stall_i),
        .s_wb_ack_i   (s_wb_ack_i),
        .grant_o      (grant_o)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    // Absolute time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: simulation still running at %0t", $time);
        $fatal(1, "timeout");
    end

    // Inputs change 1 time unit after the rising edge, well away from it.
    task automatic next_edge();
        @(posedge wb_clk_i);
        #1;
    endtask

    task automatic idle_inputs();
        m_wb_cyc_i   = '0;
        m_wb_stb_i   = '0;
        m_wb_we_i    = '0;
        m_wb_sel_i   = '0;
        m_wb_adr_i   = '0;
        m_wb_dat_i   = '0;
        s_wb_dat_i   = '0;
        s_wb_stall_i = 1'b0;
        s_wb_ack_i   = 1'b0;
    endtask

    task automatic reset_dut();
        wb_rst_i = 1'b1;
        idle_inputs();
        next_edge();
        wb_rst_i = 1'b0;
        m_owner  = -1;
        m_last   = N - 1;
    endtask

    task automatic test_reset();
        wb_rst_i = 1'b1;
        idle_inputs();
        #1;
        tests_run++;
        if (grant_o !== 2'b00) begin tests_failed++; $display("FAIL reset_grant: got %b want 00", grant_o); end
        tests_run++;
        if (s_wb_cyc_o !== 1'b0 || s_wb_stb_o !== 1'b0 || s_wb_adr_o !== 16'h0) begin
            tests_failed++; $display("FAIL reset_slave: cyc=%b stb=%b adr=%h want 0/0/0000", s_wb_cyc_o, s_wb_stb_o, s_wb_adr_o);
        end
        tests_run++;
        if (m_wb_stall_o !== 2'b11 || m_wb_ack_o !== 2'b00) begin
            tests_failed++; $display("FAIL reset_master: stall=%b ack=%b want 11/00", m_wb_stall_o, m_wb_ack_o);
        end
        m_wb_cyc_i = 2'b11;
        next_edge();
        tests_run++;
        if (grant_o !== 2'b00) begin tests_failed++; $display("FAIL reset_held_grant: got %b want 00", grant_o); end
        m_wb_cyc_i = '0;
        wb_rst_i   = 1'b0;
        next_edge();
    endtask

    task automatic test_single_master();
        m_wb_cyc_i        = 2'b01;
        m_wb_stb_i        = 2'b01;
        m_wb_we_i         = 2'b00;
        m_wb_sel_i[3:0]   = 4'hF;
        m_wb_adr_i[15:0]  = 16'h0010;
        #1;
        tests_run++;
        if (grant_o !== 2'b00 || m_wb_stall_o !== 2'b11) begin
            tests_failed++; $display("FAIL single_latency: grant=%b stall=%b want 00/11", grant_o, m_wb_stall_o);
        end
        next_edge();
        tests_run++;
        if (grant_o !== 2'b01) begin tests_failed++; $display("FAIL single_grant: got %b want 01", grant_o); end
        tests_run++;
        if (s_wb_cyc_o !== 1'b1 || s_wb_stb_o !== 1'b1 || s_wb_we_o !== 1'b0 || s_wb_adr_o !== 16'h0010) begin
            tests_failed++; $display("FAIL single_route: cyc=%b stb=%b we=%b adr=%h want 1/1/0/0010", s_wb_cyc_o, s_wb_stb_o, s_wb_we_o, s_wb_adr_o);
        end
        tests_run++;
        if (m_wb_stall_o !== 2'b10) begin tests_failed++; $display("FAIL single_stall: got %b want 10", m_wb_stall_o); end
        s_wb_ack_i = 1'b1;
        s_wb_dat_i = 32'hDEADBEEF;
        #1;
        tests_run++;
        if (m_wb_ack_o !== 2'b01 || m_wb_dat_o !== 32'hDEADBEEF || m_wb_stall_o[1] !== 1'b1) begin
            tests_failed++; $display("FAIL single_ack: ack=%b dat=%h stall1=%b want 01/deadbeef/1", m_wb_ack_o, m_wb_dat_o, m_wb_stall_o[1]);
        end
        next_edge();
        idle_inputs();
        next_edge();
        tests_run++;
        if (grant_o !== 2'b00 || s_wb_cyc_o !== 1'b0) begin
            tests_failed++; $display("FAIL single_release: grant=%b cyc=%b want 00/0", grant_o, s_wb_cyc_o);
        end
    endtask

    task automatic test_simultaneous();
        reset_dut();
        m_wb_cyc_i = 2'b11;
        m_wb_stb_i = 2'b11;
        m_wb_adr_i = {16'hB000, 16'hA000};
        next_edge();
        tests_run++;
        if (grant_o !== 2'b01 || s_wb_adr_o !== 16'hA000) begin
            tests_failed++; $display("FAIL simul_first: grant=%b adr=%h want 01/a000", grant_o, s_wb_adr_o);
        end
        next_edge();
        next_edge();
        tests_run++;
        if (grant_o !== 2'b01) begin tests_failed++; $display("FAIL simul_no_preempt: got %b want 01", grant_o); end
        m_wb_cyc_i = 2'b10;
        m_wb_stb_i = 2'b10;
        next_edge();
        tests_run++;
        if (grant_o !== 2'b00 || s_wb_cyc_o !== 1'b0) begin
            tests_failed++; $display("FAIL simul_gap: grant=%b cyc=%b want 00/0", grant_o, s_wb_cyc_o);
        end
        next_edge();
        tests_run++;
        if (grant_o !== 2'b10 || s_wb_adr_o !== 16'hB000) begin
            tests_failed++; $display("FAIL simul_second: grant=%b adr=%h want 10/b000", grant_o, s_wb_adr_o);
        end
        idle_inputs();
        next_edge();
    endtask

    // Owner drops CYC for one cycle and re-raises it; the other master must win.
    task automatic test_round_robin();
        logic [1:0] exp_g;
        reset_dut();
        m_wb_cyc_i = 2'b11;
        m_wb_stb_i = 2'b11;
        next_edge();
        exp_g = 2'b01;
        for (int r = 0; r < 6; r++) begin
            tests_run++;
            if (grant_o !== exp_g) begin tests_failed++; $display("FAIL rr_grant_%0d: got %b want %b", r, grant_o, exp_g); end
            m_wb_cyc_i = ~exp_g;
            next_edge();
            tests_run++;
            if (grant_o !== 2'b00) begin tests_failed++; $display("FAIL rr_gap_%0d: got %b want 00", r, grant_o); end
            m_wb_cyc_i = 2'b11;
            next_edge();
            exp_g = ~exp_g;
        end
        idle_inputs();
        next_edge();
    endtask

    task automatic test_stall();
        reset_dut();
        m_wb_cyc_i         = 2'b10;
        m_wb_stb_i         = 2'b10;
        m_wb_we_i          = 2'b10;
        m_wb_sel_i[7:4]    = 4'hC;
        m_wb_adr_i[31:16]  = 16'h0044;
        m_wb_dat_i[63:32]  = 32'h11223344;
        s_wb_stall_i       = 1'b1;
        next_edge();
        tests_run++;
        if (grant_o !== 2'b10) begin tests_failed++; $display("FAIL stall_grant: got %b want 10", grant_o); end
        for (int c = 0; c < 3; c++) begin
            tests_run++;
            if (m_wb_stall_o !== 2'b11 || s_wb_stb_o !== 1'b1 || s_wb_we_o !== 1'b1) begin
                tests_failed++; $display("FAIL stall_cycle_%0d: stall=%b stb=%b we=%b want 11/1/1", c, m_wb_stall_o, s_wb_stb_o, s_wb_we_o);
            end
            if (c < 2) next_edge();
        end
        s_wb_stall_i = 1'b0;
        #1;
        tests_run++;
        if (m_wb_stall_o !== 2'b01 || s_wb_dat_o !== 32'h11223344 || s_wb_sel_o !== 4'hC) begin
            tests_failed++; $display("FAIL stall_accept: stall=%b dat=%h sel=%h want 01/11223344/c", m_wb_stall_o, s_wb_dat_o, s_wb_sel_o);
        end
        next_edge();
        m_wb_stb_i = 2'b00;
        s_wb_ack_i = 1'b1;
        #1;
        tests_run++;
        if (m_wb_ack_o !== 2'b10) begin tests_failed++; $display("FAIL stall_ack: got %b want 10", m_wb_ack_o); end
        next_edge();
        s_wb_ack_i = 1'b0;
    endtask

    // Continues with m1 owning the bus from test_stall.
    task automatic test_reset_mid();
        m_wb_stb_i = 2'b10;
        m_wb_cyc_i = 2'b11;
        s_wb_ack_i = 1'b1;
        #1;
        tests_run++;
        if (grant_o !== 2'b10 || s_wb_cyc_o !== 1'b1) begin
            tests_failed++; $display("FAIL rstmid_pre: grant=%b cyc=%b want 10/1", grant_o, s_wb_cyc_o);
        end
        wb_rst_i = 1'b1;
        #1;
        tests_run++;
        if (grant_o !== 2'b00 || s_wb_cyc_o !== 1'b0 || s_wb_stb_o !== 1'b0 || m_wb_ack_o !== 2'b00) begin
            tests_failed++; $display("FAIL rstmid_async: grant=%b cyc=%b stb=%b ack=%b want 00/0/0/00", grant_o, s_wb_cyc_o, s_wb_stb_o, m_wb_ack_o);
        end
        s_wb_ack_i = 1'b0;
        m_wb_stb_i = 2'b11;
        next_edge();
        wb_rst_i = 1'b0;
        next_edge();
        tests_run++;
        if (grant_o !== 2'b01) begin tests_failed++; $display("FAIL rstmid_tie: got %b want 01", grant_o); end
    endtask

    // Continues with m0 owning the bus from test_reset_mid.
    task automatic test_isolation();
        m_wb_adr_i[15:0] = 16'h1234;
        m_wb_stb_i[0]    = 1'b1;
        for (int c = 0; c < 8; c++) begin
            m_wb_stb_i[1]      = 1'($urandom);
            m_wb_we_i[1]       = 1'($urandom);
            m_wb_adr_i[31:16]  = 16'($urandom);
            s_wb_ack_i         = 1'($urandom);
            #1;
            tests_run++;
            if (grant_o !== 2'b01 || s_wb_adr_o !== 16'h1234 || m_wb_ack_o !== {1'b0, s_wb_ack_i} || m_wb_stall_o[1] !== 1'b1) begin
                tests_failed++;
                $display("FAIL iso_%0d: grant=%b adr=%h ack=%b stall1=%b want 01/1234/0%b/1", c, grant_o, s_wb_adr_o, m_wb_ack_o, m_wb_stall_o[1], s_wb_ack_i);
            end
            next_edge();
        end
        idle_inputs();
        next_edge();
    endtask

    // Model step at a rising edge, from the CYC values sampled at that edge.
    task automatic model_edge();
        if (m_owner < 0) begin
            for (int k = 1; k <= N; k++) begin
                int c;
                c = (m_last + k) % N;
                if (m_owner < 0 && ((m_wb_cyc_i >> c) & 1) != 0) begin
                    m_owner = c;
                    m_last  = c;
                end
            end
        end else if (((m_wb_cyc_i >> m_owner) & 1) == 0) begin
            m_owner = -1;
        end
    endtask

    task automatic test_random();
        logic [N-1:0] exp_grant, exp_stall, exp_ack;
        logic [54:0]  exp_slave, act_slave;
        reset_dut();
        for (int t = 0; t < 400; t++) begin
            for (int i = 0; i < N; i++)
                if ($urandom_range(3) == 0) m_wb_cyc_i[i] = ~m_wb_cyc_i[i];
            m_wb_stb_i   = 2'($urandom);
            m_wb_we_i    = 2'($urandom);
            m_wb_sel_i   = 8'($urandom);
            m_wb_adr_i   = 32'($urandom);
            m_wb_dat_i   = {32'($urandom), 32'($urandom)};
            s_wb_dat_i   = 32'($urandom);
            s_wb_stall_i = 1'($urandom);
            s_wb_ack_i   = 1'($urandom);
            #1;
            if (m_owner < 0) begin
                exp_grant = '0;
                exp_slave = '0;
                exp_stall = '1;
                exp_ack   = '0;
            end else begin
                exp_grant = N'(1) << m_owner;
                exp_slave = {1'(m_wb_cyc_i >> m_owner), 1'(m_wb_stb_i >> m_owner), 1'(m_wb_we_i >> m_owner),
                             4'(m_wb_sel_i >> (4*m_owner)), 16'(m_wb_adr_i >> (16*m_owner)),
                             32'(m_wb_dat_i >> (32*m_owner))};
                exp_stall = ~exp_grant | (s_wb_stall_i ? exp_grant : '0);
                exp_ack   = s_wb_ack_i ? exp_grant : '0;
            end
            act_slave = {s_wb_cyc_o, s_wb_stb_o, s_wb_we_o, s_wb_sel_o, s_wb_adr_o, s_wb_dat_o};
            tests_run++;
            if (grant_o !== exp_grant) begin tests_failed++; $display("FAIL rand_grant_%0d: got %b want %b", t, grant_o, exp_grant); end
            tests_run++;
            if (act_slave !== exp_slave) begin tests_failed++; $display("FAIL rand_slave_%0d: got %h want %h", t, act_slave, exp_slave); end
            tests_run++;
            if (m_wb_stall_o !== exp_stall || m_wb_ack_o !== exp_ack || m_wb_dat_o !== s_wb_dat_i) begin
                tests_failed++;
                $display("FAIL rand_master_%0d: stall=%b ack=%b dat=%h want %b/%b/%h", t, m_wb_stall_o, m_wb_ack_o, m_wb_dat_o, exp_stall, exp_ack, s_wb_dat_i);
            end
            @(posedge wb_clk_i);
            model_edge();
            #1;
        end
        idle_inputs();
    endtask

    initial begin
        wb_rst_i = 1'b1;
        idle_inputs();
        test_reset();
        test_single_master();
        test_simultaneous();
        test_round_robin();
        test_stall();
        test_reset_mid();
        test_isolation();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
